// File: rtl/cache_read_sequencer.sv
// cache_read_sequencer
//   Walks one CPU read request at a time through a fully associative cache.
//   The flow is: tag lookup, hit compare, data read, response. A miss hands
//   the block address to the refill path, waits for the refill, then looks
//   the tag up again. After MAX_RETRY misses in a row the request gets an
//   error response.
//
//   Optional feature: define CACHE_RD_PERF_EN to add the hit_count and
//   miss_count performance counters. Both are 32 bits and saturate.
//
// Ports
//   clk, reset      : rising-edge clock, asynchronous active-high reset
//   req_*           : CPU read request (valid/ready, byte address)
//   resp_*          : CPU response (valid/ready, data word, error flag)
//   lookup_valid/tag: one-cycle tag lookup strobe to the way array
//   hit_vector      : per-way tag match, sampled the cycle after the lookup
//   rd_target_way   : one-hot way select to the data reader (READ only)
//   rd_offset       : word offset within the block (READ only)
//   rd_data         : combinational word from the data reader
//   miss_*          : refill request (valid/ready, block-aligned address)
//   refill_done     : one-cycle pulse, refill written into a way
//   hit_count/miss_count : performance counters (CACHE_RD_PERF_EN only)
module cache_read_sequencer #(
  parameter int NUM_WAYS      = 512,
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int BLOCK_WORDS   = 16,
  parameter int MAX_RETRY     = 2,
  localparam int OFFSET_W     = $clog2(BLOCK_WORDS),
  localparam int TAG_W        = ADDRESS_WIDTH - OFFSET_W - 2,
  localparam int RETRY_W      = $clog2(MAX_RETRY + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [DATA_WIDTH-1:0]    resp_data,
  output logic                     resp_err,
  output logic                     lookup_valid,
  output logic [TAG_W-1:0]         lookup_tag,
  input  logic [NUM_WAYS-1:0]      hit_vector,
  output logic [NUM_WAYS-1:0]      rd_target_way,
  output logic [OFFSET_W-1:0]      rd_offset,
  input  logic [DATA_WIDTH-1:0]    rd_data,
  output logic                     miss_valid,
  output logic [ADDRESS_WIDTH-1:0] miss_addr,
  input  logic                     miss_ready,
  input  logic                     refill_done
`ifdef CACHE_RD_PERF_EN
  ,
  output logic [31:0]              hit_count,
  output logic [31:0]              miss_count
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_COMPARE,
    S_READ,
    S_RESP,
    S_MISS,
    S_WAIT_REFILL
  } state_t;

  localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);

  state_t                   state;
  state_t                   state_next;
  logic [ADDRESS_WIDTH-1:2] addr_q;
  logic [RETRY_W-1:0]       retry_q;
  logic [RETRY_W-1:0]       retry_inc;
  logic                     retry_exhausted;
  logic [NUM_WAYS-1:0]      way_sel_q;
  logic [NUM_WAYS-1:0]      lowest_hit;
  logic                     any_hit;
  logic [DATA_WIDTH-1:0]    resp_data_q;
  logic                     resp_err_q;
  logic                     addr_lsb_unused;

  // The byte-lane bits of the address have no meaning for word reads.
  assign addr_lsb_unused = ^req_addr[1:0];

  // x & -x keeps only the lowest set bit. When several ways hit, the
  // lowest-numbered way is the one that gets read.
  assign any_hit    = |hit_vector;
  assign lowest_hit = hit_vector & (~hit_vector + NUM_WAYS'(1));

  // The retry counter saturates at MAX_RETRY. The request gives up when this
  // miss brings the count up to the limit.
  assign retry_inc       = (retry_q == RETRY_LIMIT) ? retry_q : retry_q + RETRY_W'(1);
  assign retry_exhausted = (retry_inc == RETRY_LIMIT);

  // The state register. Reset drops any request in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // The next-state logic. LOOKUP, COMPARE and READ each last one cycle.
  // The other states wait for a handshake or for the refill pulse.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:        if (req_valid) state_next = S_LOOKUP;
      S_LOOKUP:      state_next = S_COMPARE;
      S_COMPARE: begin
        if (any_hit) begin
          state_next = S_READ;
        end else if (retry_exhausted) begin
          state_next = S_RESP;
        end else begin
          state_next = S_MISS;
        end
      end
      S_READ:        state_next = S_RESP;
      S_RESP:        if (resp_ready) state_next = S_IDLE;
      S_MISS:        if (miss_ready) state_next = S_WAIT_REFILL;
      S_WAIT_REFILL: if (refill_done) state_next = S_LOOKUP;
      default:       state_next = S_IDLE;
    endcase
  end

  // Registers for the request. The address is captured on acceptance. The way
  // select and the retry count are updated in COMPARE. The response word is
  // loaded in READ, or forced to zero with the error flag when retries run out.
  // These registers keep their value through RESP until the CPU takes it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q      <= '0;
      retry_q     <= '0;
      way_sel_q   <= '0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) addr_q <= req_addr[ADDRESS_WIDTH-1:2];
        end
        S_COMPARE: begin
          if (any_hit) begin
            way_sel_q <= lowest_hit;
          end else begin
            retry_q <= retry_inc;
            if (retry_exhausted) begin
              resp_data_q <= '0;
              resp_err_q  <= 1'b1;
            end
          end
        end
        S_READ: begin
          resp_data_q <= rd_data;
          resp_err_q  <= 1'b0;
        end
        S_RESP: begin
          if (resp_ready) retry_q <= '0;
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from the state. The way select and the offset go to the
  // data reader only during READ and are zero in every other cycle.
  always_comb begin
    req_ready     = (state == S_IDLE);
    lookup_valid  = (state == S_LOOKUP);
    resp_valid    = (state == S_RESP);
    miss_valid    = (state == S_MISS);
    rd_target_way = '0;
    rd_offset     = '0;
    if (state == S_READ) begin
      rd_target_way = way_sel_q;
      rd_offset     = addr_q[OFFSET_W+1:2];
    end
  end

  assign lookup_tag = addr_q[ADDRESS_WIDTH-1:OFFSET_W+2];
  assign miss_addr  = {addr_q[ADDRESS_WIDTH-1:OFFSET_W+2], {(OFFSET_W+2){1'b0}}};
  assign resp_data  = resp_data_q;
  assign resp_err   = resp_err_q;

`ifdef CACHE_RD_PERF_EN
  // The performance counters count every COMPARE, including compares in
  // requests that later fail. Each counter holds at all-ones, not wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state == S_COMPARE) begin
      if (any_hit) begin
        if (hit_count != 32'hFFFF_FFFF) hit_count <= hit_count + 32'd1;
      end else begin
        if (miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cache_read_sequencer.sv
// Testbench for cache_read_sequencer.
//   The bench drives requests cycle by cycle and plays the way array, the
//   data reader and the refill path. It checks the lookup, read and miss
//   signals in every state of each request. Expected responses go into a
//   scoreboard queue when a request is issued. A negedge monitor pops the
//   queue at each response handshake. When CACHE_RD_PERF_EN is defined the
//   perf counters are connected and checked as well.
module tb_cache_read_sequencer;

  localparam int NW    = 512;
  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int RETRY = 2;

  typedef struct packed {
    logic          err;
    logic [DW-1:0] data;
  } resp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic          resp_valid;
  logic          resp_ready;
  logic [DW-1:0] resp_data;
  logic          resp_err;
  logic          lookup_valid;
  logic [25:0]   lookup_tag;
  logic [NW-1:0] hit_vector;
  logic [NW-1:0] rd_target_way;
  logic [3:0]    rd_offset;
  logic [DW-1:0] rd_data;
  logic          miss_valid;
  logic [AW-1:0] miss_addr;
  logic          miss_ready;
  logic          refill_done;
`ifdef CACHE_RD_PERF_EN
  logic [31:0]   hit_count;
  logic [31:0]   miss_count;
`endif

  int    num_checks = 0;
  int    num_errors = 0;
  int    cyc = 0;
  int    exp_hits = 0;
  int    exp_misses = 0;
  resp_t sb[$];
  resp_t mon_exp;

  cache_read_sequencer #(
    .NUM_WAYS(NW), .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .BLOCK_WORDS(16), .MAX_RETRY(RETRY)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_err(resp_err),
    .lookup_valid(lookup_valid), .lookup_tag(lookup_tag), .hit_vector(hit_vector),
    .rd_target_way(rd_target_way), .rd_offset(rd_offset), .rd_data(rd_data),
    .miss_valid(miss_valid), .miss_addr(miss_addr), .miss_ready(miss_ready),
    .refill_done(refill_done)
`ifdef CACHE_RD_PERF_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  // Every comparison in the bench goes through this task.
  task automatic checkOutput(input string tag, input logic [NW-1:0] observed,
                             input logic [NW-1:0] expected);
    num_checks++;
    if (observed !== expected) begin
      num_errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Steps to 1 time unit after the next rising edge. Inputs change and
  // outputs are sampled at that point.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // The lowest set bit is found with a plain scan, not with arithmetic.
  function automatic logic [NW-1:0] lowestOneHot(input logic [NW-1:0] v);
    logic [NW-1:0] r;
    r = '0;
    for (int i = 0; i < NW; i++) begin
      if (v[i]) begin
        r[i] = 1'b1;
        break;
      end
    end
    return r;
  endfunction

  // The response monitor. A handshake is visible at negedge because
  // resp_ready is driven just after posedge.
  always @(negedge clk) begin
    if (!reset && resp_valid && resp_ready) begin
      if (sb.size() == 0) begin
        checkOutput("sb_unexpected_resp", 1'b1, 1'b0);
      end else begin
        mon_exp = sb.pop_front();
        checkOutput("resp_data", resp_data, mon_exp.data);
        checkOutput("resp_err", resp_err, mon_exp.err);
      end
    end
  end

  // Runs one full request. hit_a answers the first lookup and hit_b the
  // retry. miss_stall holds off miss_ready. resp_stall holds off resp_ready.
  task automatic applyStimulus(input logic [AW-1:0] addr, input logic [NW-1:0] hit_a,
                               input logic [NW-1:0] hit_b, input logic [DW-1:0] data,
                               input int miss_stall, input int resp_stall);
    logic [NW-1:0] hits [2];
    resp_t         e;
    int            t_req;
    logic          first_hit;
    hits[0]   = hit_a;
    hits[1]   = hit_b;
    first_hit = (hit_a != '0);
    e.err  = (hit_a == '0) && (hit_b == '0);
    e.data = e.err ? '0 : data;
    sb.push_back(e);

    checkOutput("req_ready_idle", req_ready, 1'b1);
    req_valid = 1'b1;
    req_addr  = addr;
    t_req     = cyc;
    tick();
    req_valid = 1'b0;
    req_addr  = $urandom;

    for (int n = 0; n < RETRY; n++) begin
      checkOutput("lookup_valid", lookup_valid, 1'b1);
      checkOutput("lookup_tag", lookup_tag, addr[31:6]);
      checkOutput("req_ready_busy", req_ready, 1'b0);
      hit_vector = hits[n];
      rd_data    = data;
      tick();
      checkOutput("lookup_pulse", lookup_valid, 1'b0);
      checkOutput("target_outside_read", rd_target_way, '0);
      tick();
      hit_vector = '0;
      if (hits[n] != '0) begin
        exp_hits++;
        checkOutput("rd_target_way", rd_target_way, lowestOneHot(hits[n]));
        checkOutput("rd_offset", rd_offset, addr[5:2]);
        tick();
        rd_data = $urandom;
        checkOutput("target_one_cycle", rd_target_way, '0);
        checkOutput("offset_outside_read", rd_offset, 4'h0);
        break;
      end
      exp_misses++;
      if (n == RETRY - 1) break;
      checkOutput("miss_valid", miss_valid, 1'b1);
      checkOutput("miss_addr", miss_addr, {addr[31:6], 6'b0});
      for (int s = 0; s < miss_stall; s++) begin
        tick();
        checkOutput("miss_hold_valid", miss_valid, 1'b1);
        checkOutput("miss_hold_addr", miss_addr, {addr[31:6], 6'b0});
      end
      miss_ready = 1'b1;
      tick();
      miss_ready = 1'b0;
      for (int w = 0; w < 2; w++) begin
        checkOutput("wait_no_miss", miss_valid, 1'b0);
        checkOutput("wait_no_lookup", lookup_valid, 1'b0);
        tick();
      end
      refill_done = 1'b1;
      tick();
      refill_done = 1'b0;
    end

    checkOutput("resp_valid", resp_valid, 1'b1);
    checkOutput("single_miss", miss_valid, 1'b0);
    if (first_hit) checkOutput("hit_latency", cyc - t_req, 4);
    for (int s = 0; s < resp_stall; s++) begin
      tick();
      checkOutput("resp_hold_valid", resp_valid, 1'b1);
      checkOutput("resp_hold_data", resp_data, e.data);
      checkOutput("resp_hold_req_ready", req_ready, 1'b0);
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    checkOutput("resp_done", resp_valid, 1'b0);
    checkOutput("req_ready_after", req_ready, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [NW-1:0] hv;
    reset       = 1'b1;
    req_valid   = 1'b0;
    req_addr    = '0;
    resp_ready  = 1'b0;
    hit_vector  = '0;
    rd_data     = '0;
    miss_ready  = 1'b0;
    refill_done = 1'b0;
    tick();
    tick();
    checkOutput("rst_req_ready", req_ready, 1'b1);
    checkOutput("rst_resp_valid", resp_valid, 1'b0);
    checkOutput("rst_lookup_valid", lookup_valid, 1'b0);
    checkOutput("rst_miss_valid", miss_valid, 1'b0);
    checkOutput("rst_target", rd_target_way, '0);
    checkOutput("rst_resp_data", resp_data, '0);
    reset = 1'b0;
    tick();

    // A single hit on way 7.
    hv = '0; hv[7] = 1'b1;
    applyStimulus(32'h0000_1234, hv, '0, 32'hDEAD_BEEF, 0, 0);
    // Several ways hit. The lowest way, 3, must be the one read.
    hv = '0; hv[3] = 1'b1; hv[9] = 1'b1; hv[500] = 1'b1;
    applyStimulus(32'h0000_ABC8, hv, '0, 32'h1234_5678, 0, 1);
    // A miss with a stalled refill path, then a hit on way 0.
    hv = '0; hv[0] = 1'b1;
    applyStimulus(32'h0000_1234, '0, hv, 32'hCAFE_F00D, 3, 0);
    // Both lookups miss, so the request ends with an error response.
    applyStimulus(32'h0000_8004, '0, '0, 32'h5555_AAAA, 0, 0);
    // The retry count must start from zero again, or this first miss would
    // end in an error.
    hv = '0; hv[NW-1] = 1'b1;
    applyStimulus(32'h00FF_FFFC, '0, hv, 32'h0BAD_C0DE, 1, 0);
    // Response backpressure held for five cycles.
    hv = '0; hv[256] = 1'b1;
    applyStimulus(32'hFFFF_FFC0, hv, '0, 32'hA5A5_5A5A, 0, 5);
    // A few random hits.
    for (int k = 0; k < 4; k++) begin
      hv = '0;
      hv[$urandom_range(NW-1, 0)] = 1'b1;
      hv[$urandom_range(NW-1, 0)] = 1'b1;
      applyStimulus($urandom, hv, '0, $urandom, 0, $urandom_range(2, 0));
    end

`ifdef CACHE_RD_PERF_EN
    checkOutput("perf_hit_count", hit_count, exp_hits);
    checkOutput("perf_miss_count", miss_count, exp_misses);
`endif

    // Reset during WAIT_REFILL abandons the request. The late refill pulse
    // that follows must cause no activity.
    req_valid = 1'b1;
    req_addr  = 32'h0000_2000;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    checkOutput("rst_pre_miss", miss_valid, 1'b1);
    miss_ready = 1'b1;
    tick();
    miss_ready = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    checkOutput("midrst_req_ready", req_ready, 1'b1);
    checkOutput("midrst_miss_valid", miss_valid, 1'b0);
    checkOutput("midrst_miss_addr", miss_addr, '0);
    checkOutput("midrst_lookup_tag", lookup_tag, '0);
    checkOutput("midrst_resp_valid", resp_valid, 1'b0);
    checkOutput("midrst_resp_data", resp_data, '0);
    checkOutput("midrst_resp_err", resp_err, 1'b0);
`ifdef CACHE_RD_PERF_EN
    checkOutput("midrst_hit_count", hit_count, '0);
    checkOutput("midrst_miss_count", miss_count, '0);
`endif
    tick();
    reset       = 1'b0;
    refill_done = 1'b1;
    tick();
    refill_done = 1'b0;
    for (int c = 0; c < 5; c++) begin
      checkOutput("post_rst_lookup", lookup_valid, 1'b0);
      checkOutput("post_rst_miss", miss_valid, 1'b0);
      checkOutput("post_rst_resp", resp_valid, 1'b0);
      checkOutput("post_rst_idle", req_ready, 1'b1);
      tick();
    end
    checkOutput("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule

// File: doc/cache_read_sequencer.md
Name: cache_read_sequencer

Overview:
- Sequences CPU read requests through a fully associative, NUM_WAYS-way cache.
- Flow per request: issues a tag lookup to the ways, converts the returned hit vector into a one-hot way select, then drives the way data reader's target/offset and registers the returned word.
- On a miss, hands the address to the refill path, waits for refill completion, then retries.
- Sits between the CPU request/response port and the way array / way data reader.

Parameters:
- NUM_WAYS, 512, number of ways; width of the hit and target vectors.
- DATA_WIDTH, 32, width of a data word.
- ADDRESS_WIDTH, 32, width of a CPU byte address.
- BLOCK_WORDS, 16, words per block; OFFSET_W = $clog2(BLOCK_WORDS).
- MAX_RETRY, 2, number of consecutive misses on one request before an error response.

Ports:
- clk in 1: single clock, rising edge.
- reset in 1: asynchronous, active-high reset.
- req_valid in 1: CPU read request valid.
- req_ready out 1: sequencer can accept a request.
- req_addr in ADDRESS_WIDTH: byte address; bits [1:0] are ignored.
- resp_valid out 1: response valid.
- resp_ready in 1: CPU accepts the response.
- resp_data out DATA_WIDTH: read word.
- resp_err out 1: request failed after MAX_RETRY misses.
- lookup_valid out 1: one-cycle tag lookup strobe to the ways.
- lookup_tag out ADDRESS_WIDTH-OFFSET_W-2: tag = req_addr[ADDRESS_WIDTH-1 : OFFSET_W+2].
- hit_vector in NUM_WAYS: per-way tag match; valid the cycle after lookup_valid.
- rd_target_way out NUM_WAYS: one-hot way select to the data reader.
- rd_offset out OFFSET_W: word offset = req_addr[OFFSET_W+1:2].
- rd_data in DATA_WIDTH: combinational data from the data reader.
- miss_valid out 1: refill request valid.
- miss_addr out ADDRESS_WIDTH: block-aligned miss address (low OFFSET_W+2 bits zero).
- miss_ready in 1: refill path accepts the miss.
- refill_done in 1: one-cycle pulse; the refill has been written into a way.

Behaviour:
- Reset (async, active-high): state IDLE, retry counter 0, address register 0, all outputs 0 except req_ready = 1.
- Reset mid-operation abandons the request; no response and no miss is issued afterwards.
- req_ready = (state == IDLE). A request is accepted when req_valid && req_ready; req_addr is latched into the address register.
- IDLE -> LOOKUP on acceptance.
- LOOKUP (1 cycle): lookup_valid = 1, lookup_tag driven from the address register. Next state COMPARE.
- COMPARE (1 cycle): sample hit_vector.
  - Any bit set: register a one-hot of the lowest set index (multi-hit resolves to the lowest way); next state READ.
  - All zero: increment the retry counter. If the counter reaches MAX_RETRY, go to RESP with resp_err = 1 and resp_data = 0; otherwise go to MISS.
- READ (1 cycle): rd_target_way = registered one-hot, rd_offset driven; rd_data is registered into resp_data at the end of the cycle. Next state RESP.
- rd_target_way is all-zero in every state except READ; rd_offset is 0 outside READ.
- RESP: resp_valid = 1; resp_data and resp_err are held stable until resp_ready. On handshake, clear the retry counter and return to IDLE.
- Hit latency: acceptance edge at cycle 0 -> resp_valid high in cycle 4. A new request can be accepted the cycle after the response handshake.
- MISS: miss_valid = 1 with miss_addr held until miss_ready. Next state WAIT_REFILL.
- WAIT_REFILL: wait for refill_done, then go to LOOKUP.
  - refill_done in any other state is ignored.
  - refill_done arriving in the same cycle as the miss handshake is not recognised; the refill path guarantees at least one cycle of separation.
- The retry counter saturates and is $clog2(MAX_RETRY+1) bits wide.

Optional Feature:
- Macro: CACHE_RD_PERF_EN.
- Defined:
  - Adds output ports hit_count (32) and miss_count (32), both reset to 0.
  - hit_count increments on every COMPARE that finds a hit.
  - miss_count increments on every COMPARE that finds no hit.
  - Both saturate at 32'hFFFF_FFFF.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Hit: req_addr 0x0000_1234, hit_vector bit 7 set in COMPARE, rd_data 0xDEADBEEF -> lookup_tag 0x000048, rd_offset 0xD, rd_target_way only bit 7 for exactly 1 cycle, resp_valid in cycle 4 with resp_data 0xDEADBEEF, resp_err 0.
- Multi-hit: hit_vector bits 3, 9 and 500 set -> rd_target_way only bit 3.
- Miss then hit: first COMPARE all zero -> miss_valid with miss_addr 0x0000_1200. Hold miss_ready low 3 cycles -> miss_valid and miss_addr stay stable. After refill_done, the second lookup hits bit 0 -> correct data, resp_err 0.
- Retry exhaustion: MAX_RETRY = 2, both lookups miss -> exactly one miss issued, then resp_valid with resp_err = 1 and resp_data 0; next request starts with the retry counter at 0.
- Backpressure and reset: hold resp_ready low 5 cycles -> resp_data stable and req_ready 0. Assert reset while in WAIT_REFILL -> all outputs 0 and req_ready 1 immediately; a later refill_done produces no activity.
- With CACHE_RD_PERF_EN defined: 3 hits and 1 miss -> hit_count 3, miss_count 1; reset clears both to 0.
